// File: rtl/pipe_stage_reg_pkg.sv
// Shared state encoding and occupancy helper for the pipeline-stage controllers.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'b00,
    ST_FULL      = 2'b01,
    ST_SKID_FULL = 2'b10
  } state_t;

  function automatic logic [1:0] state_count(input state_t s);
    case (s)
      ST_FULL:      state_count = 2'd1;
      ST_SKID_FULL: state_count = 2'd2;
      default:      state_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_reg_register.sv
// N-bit load-enabled register with asynchronous active-low reset to RESET_VAL.
module pipe_stage_reg_register #(
  parameter int            N         = 32,
  parameter logic [N-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      q <= RESET_VAL;
    else if (load) q <= d;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage with optional skid slot and synchronous flush.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int            N         = 32,
  parameter bit            SKID      = 1'b1,
  parameter logic [N-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   count
);

  state_t       state, state_nx;
  logic         acc, drn, load_main, rdy_nx;
  logic [N-1:0] main_d, skid_q;

  assign acc = in_valid & in_ready;
  assign drn = out_valid & out_ready;

  always_comb begin
    state_nx  = ST_EMPTY;
    load_main = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (acc) begin
          state_nx  = ST_FULL;
          load_main = 1'b1;
        end
      end
      ST_FULL: begin
        if (acc && drn) begin
          state_nx  = ST_FULL;
          load_main = 1'b1;
        end else if (drn)          state_nx = ST_EMPTY;
        else if (acc && SKID)      state_nx = ST_SKID_FULL;
        else                       state_nx = ST_FULL;
      end
      ST_SKID_FULL: begin
        // Without a skid slot this encoding is illegal and falls back to EMPTY.
        if (SKID) begin
          if (drn) begin
            state_nx  = ST_FULL;
            load_main = 1'b1;
          end else begin
            state_nx  = ST_SKID_FULL;
          end
        end
      end
      default: state_nx = ST_EMPTY;
    endcase
    if (flush) begin
      state_nx  = ST_EMPTY;
      load_main = 1'b0;
    end
  end

  // Ready is a function of next state only, so there is no comb path from out_ready.
  assign rdy_nx = SKID ? (state_nx != ST_SKID_FULL) : (state_nx == ST_EMPTY);
  assign main_d = (state == ST_SKID_FULL) ? skid_q : in_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      count     <= 2'd0;
    end else begin
      state     <= state_nx;
      in_ready  <= rdy_nx;
      out_valid <= (state_nx != ST_EMPTY);
      count     <= state_count(state_nx);
    end
  end

  pipe_stage_reg_register #(.N(N), .RESET_VAL(RESET_VAL)) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (load_main),
    .d    (main_d),
    .q    (out_data)
  );

  if (SKID) begin : g_skid
    logic load_skid;
    assign load_skid = acc & ~drn & ~flush & (state == ST_FULL);
    pipe_stage_reg_register #(.N(N), .RESET_VAL(RESET_VAL)) u_skid (
      .clk  (clk),
      .rst  (rst),
      .load (load_skid),
      .d    (in_data),
      .q    (skid_q)
    );
  end else begin : g_noskid
    assign skid_q = RESET_VAL;
  end

endmodule
